// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state encodings
// and the NOP word presented to ID whenever no valid instruction is held.
package if_fetch_pkg;

    // FETCH: request the current pc
    // DROP : a flush left a request in flight; wait out its stale ack
    // HOLD : ID is stalled and the skid entry is occupied; no new request
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DROP  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // Encoding of the instruction shown to ID while nothing valid is held
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_skid_buf.sv
// Output register toward the ID stage plus a single skid entry.
// A word loaded while ID is stalled on a valid instruction goes to the skid
// and moves to the output once the stall releases. A flush empties both.
module if_fetch_skid_buf
    import if_fetch_pkg::*;
#(
    parameter int              AW          = 32,
    parameter int              DW          = 32,
    parameter logic [DW-1:0]   RESET_INSTR = DW'(NOP_INSTR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] in_instr,
    input  logic [AW-1:0] in_pc,
    input  logic          id_stall,
    input  logic          flush,
    output logic          out_valid,
    output logic [DW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic          full
);

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_instr_q, out_instr_d;
    logic [AW-1:0] out_pc_q,    out_pc_d;
    logic          skid_full_q, skid_full_d;
    logic [DW-1:0] skid_instr_q, skid_instr_d;
    logic [AW-1:0] skid_pc_q,    skid_pc_d;

    // Next-state of output register and skid: flush first, then skid drain, then new load
    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_full_d  = skid_full_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (skid_full_q) begin
            if (!id_stall) begin
                out_valid_d = 1'b1;
                out_instr_d = skid_instr_q;
                out_pc_d    = skid_pc_q;
                skid_full_d = 1'b0;
            end
        end else if (load) begin
            if (!out_valid_q || !id_stall) begin
                out_valid_d = 1'b1;
                out_instr_d = in_instr;
                out_pc_d    = in_pc;
            end else begin
                skid_full_d  = 1'b1;
                skid_instr_d = in_instr;
                skid_pc_d    = in_pc;
            end
        end else if (!id_stall) begin
            out_valid_d = 1'b0;
        end

        if (!out_valid_d) begin
            out_instr_d = RESET_INSTR;
        end
    end

    // State registers with synchronous reset to an empty buffer showing NOP
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= RESET_INSTR;
            out_pc_q     <= '0;
            skid_full_q  <= 1'b0;
            skid_instr_q <= RESET_INSTR;
            skid_pc_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_full_q  <= skid_full_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign full      = skid_full_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end. Takes the pc from the PC generator, reads the
// word from instruction memory over a req/ack handshake (one request in
// flight at most) and hands {instr, pc} to ID through a skid buffer.
// stall_if holds the PC generator until the current pc has been fetched;
// a flush always releases it so the redirect target can load.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int            AW          = 32,
    parameter int            DW          = 32,
    parameter logic [DW-1:0] RESET_INSTR = DW'(NOP_INSTR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus_1_if,
    output logic          stall_if,
    input  logic          flush,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic          instr_valid_id,
    output logic [DW-1:0] instr_id,
    output logic [AW-1:0] pc_id,
    input  logic          id_stall
);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] drop_addr_q, drop_addr_d;
    logic          buf_load;
    logic          buf_full;

    // Next state, drop address capture, buffer load and address mux
    always_comb begin
        state_d     = state_q;
        drop_addr_d = drop_addr_q;
        buf_load    = 1'b0;
        imem_addr   = pc;

        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    if (!flush) begin
                        buf_load = 1'b1;
                        if (instr_valid_id && id_stall) begin
                            state_d = ST_HOLD;
                        end
                    end
                end else if (flush) begin
                    drop_addr_d = pc;
                    state_d     = ST_DROP;
                end
            end
            ST_DROP: begin
                imem_addr = drop_addr_q;
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (flush || !id_stall) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // FSM state and drop address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            drop_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // A request is never raised while the skid holds an unconsumed word
    assign imem_req = !rst && (state_q != ST_HOLD) && !buf_full;

    assign stall_if = !flush && !((state_q == ST_FETCH) && imem_ack);

    assign pc_plus_1_if = pc + AW'(1);

    if_fetch_skid_buf #(
        .AW          (AW),
        .DW          (DW),
        .RESET_INSTR (RESET_INSTR)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .in_instr  (imem_rdata),
        .in_pc     (pc),
        .id_stall  (id_stall),
        .flush     (flush),
        .out_valid (instr_valid_id),
        .out_instr (instr_id),
        .out_pc    (pc_id),
        .full      (buf_full)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch. The bench plays PC generator, instruction
// memory (random ack latency, rdata = addr ^ 32'hA5) and ID stage.
// Reference model: every pc whose fetch completes without a flush joins an
// in-order queue toward ID; ID consumes the head when not stalled; a flush
// empties the queue. Fetch can run at most two words ahead of ID, so a
// request is expected exactly when fewer than two words are waiting.
module tb_if_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_item_t;

    localparam int          NUM_CYCLES = 3000;
    localparam int          RST_CYCLES = 3;
    localparam int          DIRECTED_END = RST_CYCLES + 20;
    localparam logic [31:0] RDATA_XOR = 32'h0000_00A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] pc_plus_1_if;
    logic        stall_if;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid_id;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic        id_stall = 1'b1;

    int          n_checks = 0;
    int          n_fail = 0;

    fetch_item_t exp_q[$];
    logic [31:0] pc_reg = '0;
    logic [31:0] flush_target = '0;
    logic        busy = 1'b0;
    logic [31:0] busy_addr = '0;
    int          lat_left = 0;
    logic        stale = 1'b0;
    logic        directed = 1'b1;
    logic        rst_pending = 1'b0;
    logic        reset_done = 1'b0;
    logic        after_rst = 1'b0;

    if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_plus_1_if   (pc_plus_1_if),
        .stall_if       (stall_if),
        .flush          (flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid_id (instr_valid_id),
        .instr_id       (instr_id),
        .pc_id          (pc_id),
        .id_stall       (id_stall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive the control inputs for one cycle (called at the falling edge)
    task automatic applyStimulus(input int cyc);
        if (cyc < RST_CYCLES || rst_pending) begin
            rst      = 1'b1;
            flush    = 1'b0;
            id_stall = 1'b1;
            if (cyc >= RST_CYCLES) begin
                reset_done = 1'b1;
            end
            rst_pending = 1'b0;
        end else begin
            rst      = 1'b0;
            directed = (cyc < DIRECTED_END);
            flush    = !directed && ($urandom_range(0, 99) < 8);
            id_stall = !directed && ($urandom_range(0, 99) < 40);
            flush_target = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
        pc       = pc_reg;
        imem_ack = 1'b0;
    endtask

    // Instruction memory: one outstanding request, random latency, address held until ack
    task automatic memoryRespond();
        if (rst) begin
            imem_ack = 1'b0;
            busy     = 1'b0;
        end else if (imem_req) begin
            if (!busy) begin
                checkOutput("imem_addr_new_req", imem_addr, pc_reg);
                busy      = 1'b1;
                busy_addr = imem_addr;
                if (directed || $urandom_range(0, 1) == 0) begin
                    lat_left = 0;
                end else begin
                    lat_left = $urandom_range(1, 3);
                end
            end else begin
                checkOutput("imem_addr_stable", imem_addr, busy_addr);
            end
            if (lat_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ RDATA_XOR;
                busy       = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                lat_left--;
            end
        end else begin
            imem_ack = 1'b0;
            if (busy) begin
                checkOutput("imem_req_held_until_ack", imem_req, 1'b1);
                busy = 1'b0;
            end
        end
    endtask

    // Stimulus process: drive, respond, check stall/pc+1, update the model
    initial begin
        logic exp_stall;
        $display("[TB] if_fetch randomized scoreboard run, %0d cycles", NUM_CYCLES);
        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(negedge clk);
            applyStimulus(cyc);
            #1;
            memoryRespond();
            #2;
            if (rst) begin
                pc_reg = '0;
                stale  = 1'b0;
            end else begin
                exp_stall = !(flush || (imem_ack && !stale));
                checkOutput("stall_if", stall_if, exp_stall);
                checkOutput("pc_plus_1_if", pc_plus_1_if, pc_reg + 32'd1);
                if (imem_ack && !stale && !flush) begin
                    exp_q.push_back('{pc: pc_reg, instr: pc_reg ^ RDATA_XOR});
                end
                if (imem_ack) begin
                    stale = 1'b0;
                end else if (flush && busy) begin
                    stale = 1'b1;
                end
                if (flush) begin
                    pc_reg = flush_target;
                end else if (!exp_stall) begin
                    pc_reg = pc_reg + 32'd1;
                end
                if (!reset_done && cyc > 300 && stale) begin
                    rst_pending = 1'b1;
                end
            end
        end
        pc = 32'hFFFF_FFFF;
        #1;
        checkOutput("pc_plus_1_wrap", pc_plus_1_if, 32'h0);
        checkOutput("reset_in_drop_exercised", {31'b0, reset_done}, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor: compare ID-side outputs and request against the model queue each cycle
    initial begin
        fetch_item_t head;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                checkOutput("imem_req_in_reset", {31'b0, imem_req}, 32'h0);
            end else begin
                checkOutput("imem_req", {31'b0, imem_req}, {31'b0, exp_q.size() < 2});
            end
            checkOutput("instr_valid_id", {31'b0, instr_valid_id}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                if (instr_valid_id) begin
                    checkOutput("pc_id", pc_id, head.pc);
                    checkOutput("instr_id", instr_id, head.instr);
                end
                if (!id_stall && !rst) begin
                    void'(exp_q.pop_front());
                end
            end else begin
                checkOutput("instr_id_nop_when_invalid", instr_id, 32'h0);
            end
            if (after_rst) begin
                checkOutput("pc_id_after_reset", pc_id, 32'h0);
            end
            after_rst = rst;
            if (flush || rst) begin
                exp_q.delete();
            end
        end
    end

endmodule
